// File: rtl/l1_bus_requester.sv
// ---------------------------------------------------------------------------
// l1_bus_requester
//   Bus-side agent for one L1 cache. It accepts a single miss or writeback
//   from the L1 controller, arbitrates for the request bus, and then either
//   waits for the matching fill on the response bus (GETS/GETM) or
//   arbitrates for the response bus and pushes the victim line to memory
//   (PUTM). Only one transaction is in flight at any time.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   miss_valid/miss_ready     request handshake from the L1 controller
//   miss_op, miss_addr        transaction type and line address
//   wb_dirty, wb_data         PUTM victim line state and data
//   fill_valid/data/state     one-cycle fill return to L1 (01 S, 10 E, 11 M)
//   wb_done                   one-cycle PUTM completion pulse
//   req_bus_req/gnt/tx        request-bus arbitration and message
//   resp_bus_msg              response bus, snooped every cycle
//   resp_bus_req/gnt/tx       response-bus arbitration and message
// ---------------------------------------------------------------------------
package l1_bus_pkg;
  localparam int XLEN   = 32;
  localparam int LINE_W = 256;
  localparam int CORE_W = 2;
  localparam int WAY_W  = 2;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    GETS     = 2'd1,
    GETM     = 2'd2,
    PUTM     = 2'd3
  } bus_tx_t;

  typedef enum logic [1:0] {
    NODATA    = 2'd0,
    DATA      = 2'd1,
    EXCLUSIVE = 2'd2
  } mmsg_t;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] source;
    logic [XLEN-1:0]   addr;
    bus_tx_t           bus_tx;
  } req_msg_t;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] source;
    logic [WAY_W-1:0]  way;
    logic [CORE_W-1:0] destination;
    logic              memory_flag;
    logic [XLEN-1:0]   addr;
    logic [LINE_W-1:0] data;
    mmsg_t             mmsg;
  } resp_msg_t;
endpackage

module l1_bus_requester
  import l1_bus_pkg::*;
#(
  parameter int ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  bus_tx_t           miss_op,
  input  logic [XLEN-1:0]   miss_addr,
  input  logic              wb_dirty,
  input  logic [LINE_W-1:0] wb_data,
  output logic              miss_ready,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic [1:0]        fill_state,
  output logic              wb_done,
  output logic              req_bus_req,
  input  logic              req_bus_gnt,
  output req_msg_t          req_bus_tx,
  input  resp_msg_t         resp_bus_msg,
  output logic              resp_bus_req,
  input  logic              resp_bus_gnt,
  output resp_msg_t         resp_bus_tx
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_ARB   = 3'd1,
    WAIT_FILL = 3'd2,
    WB_ARB    = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CORE_W-1:0] MY_ID = CORE_W'(ID);

  state_t            state, state_nxt;

  bus_tx_t           op_p0;
  logic [XLEN-1:0]   addr_p0;
  logic              dirty_p0;
  logic [LINE_W-1:0] wb_data_p0;

  logic              fill_hit;
  logic              wb_hit;
  logic              resp_match;

  logic              vld_p1;
  logic              wb_vld_p1;
  logic [LINE_W-1:0] fill_data_p1;
  logic [1:0]        fill_state_p1;

  // Source and way of incoming responses carry no meaning for this agent.
  logic              unused_resp_fields;
  assign unused_resp_fields = ^{resp_bus_msg.source, resp_bus_msg.way};

  // Permission granted to L1: a GETM always ends in M; a GETS ends in E only
  // when memory says nobody else holds the line.
  function automatic logic [1:0] grant_state(input bus_tx_t op, input mmsg_t m);
    if (op == GETM)
      return 2'b11;
    else if (m == EXCLUSIVE)
      return 2'b10;
    else
      return 2'b01;
  endfunction

  assign resp_match = resp_bus_msg.valid
                   && (resp_bus_msg.destination == MY_ID)
                   && !resp_bus_msg.memory_flag
                   && (resp_bus_msg.addr == addr_p0);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Bus outputs are decoded from the state so they are held stable for as
  // long as the state waits on its grant, and fall to zero everywhere else.
  always_comb begin
    state_nxt    = state;
    miss_ready   = 1'b0;
    req_bus_req  = 1'b0;
    req_bus_tx   = '0;
    resp_bus_req = 1'b0;
    resp_bus_tx  = '0;
    fill_hit     = 1'b0;
    wb_hit       = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid)
          state_nxt = REQ_ARB;
      end
      REQ_ARB: begin
        req_bus_req       = 1'b1;
        req_bus_tx.valid  = 1'b1;
        req_bus_tx.source = MY_ID;
        req_bus_tx.addr   = addr_p0;
        req_bus_tx.bus_tx = op_p0;
        if (req_bus_gnt)
          state_nxt = (op_p0 == PUTM) ? WB_ARB : WAIT_FILL;
      end
      WAIT_FILL: begin
        if (resp_match) begin
          fill_hit  = 1'b1;
          state_nxt = DONE;
        end
      end
      WB_ARB: begin
        resp_bus_req            = 1'b1;
        resp_bus_tx.valid       = 1'b1;
        resp_bus_tx.source      = MY_ID;
        resp_bus_tx.way         = '0;
        resp_bus_tx.destination = '0;
        resp_bus_tx.memory_flag = 1'b1;
        resp_bus_tx.addr        = addr_p0;
        resp_bus_tx.data        = wb_data_p0;
        resp_bus_tx.mmsg        = dirty_p0 ? DATA : NODATA;
        if (resp_bus_gnt) begin
          wb_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: transaction captured at acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && miss_valid) begin
      op_p0      <= miss_op;
      addr_p0    <= miss_addr;
      dirty_p0   <= wb_dirty;
      wb_data_p0 <= wb_data;
    end
  end

  // Stage p1: completion pulses, presented during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      wb_vld_p1 <= 1'b0;
    end else begin
      vld_p1    <= fill_hit;
      wb_vld_p1 <= wb_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_hit) begin
      fill_data_p1  <= resp_bus_msg.data;
      fill_state_p1 <= grant_state(op_p0, resp_bus_msg.mmsg);
    end
  end

  assign fill_valid = vld_p1;
  assign fill_data  = fill_data_p1;
  assign fill_state = fill_state_p1;
  assign wb_done    = wb_vld_p1;

endmodule

// File: doc/l1_bus_requester.md
L1_BUS_REQUESTER -- requirements
Module: l1_bus_requester

Interface
REQ-001 Parameter ID, default 0: core identifier; driven as the source of every message and matched against resp_bus_msg.destination.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 miss_valid  input  1  L1 controller requests a bus transaction.
REQ-005 miss_op  input  bus_tx_t  requested transaction: GETS, GETM or PUTM.
REQ-006 miss_addr  input  XLEN  line address of the transaction.
REQ-007 wb_dirty  input  1  PUTM only: line is dirty.
REQ-008 wb_data  input  256  PUTM only: victim line data.
REQ-009 miss_ready  output  1  block is in IDLE and accepts miss_valid.
REQ-010 fill_valid  output  1  one-cycle pulse: fill data is returned to L1.
REQ-011 fill_data  output  256  line data; valid only while fill_valid is high.
REQ-012 fill_state  output  2  granted permission: 01 S, 10 E, 11 M; valid only while fill_valid is high.
REQ-013 wb_done  output  1  one-cycle pulse: PUTM completed.
REQ-014 req_bus_req / req_bus_gnt  output / input  1 / 1  request-bus arbiter handshake.
REQ-015 req_bus_tx  output  req_msg_t  request-bus message: valid, source, addr, bus_tx.
REQ-016 resp_bus_msg  input  resp_msg_t  active response-bus message, snooped every cycle.
REQ-017 resp_bus_req / resp_bus_gnt  output / input  1 / 1  response-bus arbiter handshake.
REQ-018 resp_bus_tx  output  resp_msg_t  response-bus message: valid, source, way, destination, memory_flag, addr, data, mmsg.

Function
REQ-019 FSM states: IDLE, REQ_ARB, WAIT_FILL, WB_ARB, DONE.
REQ-020 miss_ready SHALL be 1 only in IDLE; miss_valid outside IDLE is ignored.
REQ-021 Acceptance: in IDLE with miss_valid=1, the block latches miss_op, miss_addr, wb_dirty and wb_data, then enters REQ_ARB on the next edge.
REQ-022 REQ_ARB: req_bus_req=1 and req_bus_tx={valid 1, source ID, addr latched, bus_tx latched}; both are held stable until the grant.
REQ-023 A transfer occurs on the edge where req_bus_req and req_bus_gnt are both 1.
  - After the transfer, req_bus_req=0 and req_bus_tx.valid=0 on the following cycle.
  - GETS or GETM: next state WAIT_FILL.
  - PUTM: next state WB_ARB.
REQ-024 WAIT_FILL accepts a response only if all hold: resp_bus_msg.valid=1, destination==ID, memory_flag=0, addr==latched addr. Other messages are ignored.
REQ-025 On an accepted response, the next cycle SHALL pulse fill_valid=1 with fill_data=resp_bus_msg.data, then enter DONE.
  - fill_state: GETM -> 11.
  - GETS with mmsg EXCLUSIVE -> 10.
  - GETS with mmsg DATA -> 01.
REQ-026 WB_ARB: resp_bus_req=1 and resp_bus_tx={valid 1, source ID, way 0, destination 0, memory_flag 1, addr latched, data latched, mmsg}.
  - mmsg = DATA if wb_dirty, else NODATA.
  - Held stable until resp_bus_gnt; on the grant edge, wb_done pulses next cycle and the FSM enters DONE.
REQ-027 DONE lasts exactly one cycle, then IDLE; no bus request is asserted in DONE.
REQ-028 Minimum latencies, measured from acceptance with the grant available immediately:
  - PUTM: wb_done 3 cycles after acceptance.
  - GET: fill_valid 1 cycle after the accepted response.
REQ-029 Any response matching ID that arrives in IDLE, REQ_ARB or WB_ARB SHALL be ignored with no output effect.
REQ-030 A grant arriving while the corresponding req output is 0 SHALL be ignored.
REQ-031 At most one transaction is outstanding; req_bus_req and resp_bus_req are never high in the same cycle.

Reset
REQ-032 Reset SHALL force the following, including in the middle of a transaction (the in-flight transaction is dropped):
  - FSM to IDLE.
  - req_bus_req=0, resp_bus_req=0, fill_valid=0, wb_done=0.
  - req_bus_tx and resp_bus_tx to all-zero.
  - miss_ready=1 on the first cycle after reset deasserts.

Verification
REQ-033 GETS with addr 0x1000, gnt after 2 cycles, then response {dest ID, EXCLUSIVE, data 0xA5..} -> req_bus_tx.bus_tx=GETS held 3 cycles; fill_valid=1 once, fill_state=10, fill_data=0xA5..
REQ-034 GETM with a grant the same cycle, then response DATA -> fill_state=11; a response with destination ID+1 that precedes it produces no fill.
REQ-035 PUTM with wb_dirty=1, data 0x5A.. -> after the req grant, resp_bus_tx={memory_flag 1, mmsg DATA, data 0x5A..}; wb_done pulses 1 cycle after resp_bus_gnt.
REQ-036 PUTM with wb_dirty=0 -> resp_bus_tx.mmsg=NODATA; miss_valid during WB_ARB is ignored and miss_ready=0.
REQ-037 rst asserted during WAIT_FILL, then a matching response -> no fill_valid; outputs at reset values; miss_ready=1.
REQ-038 Response with a matching destination but an address differing in bit 5 -> ignored; the FSM stays in WAIT_FILL.
